// File: rtl/loa_pkg.sv
// loa_pkg: shared logic-analyser types and default sizes
package loa_pkg;
  localparam int LOA_DW = 8;
  localparam int LOA_DEPTH = 256;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} loa_state_t;
endpackage

// File: rtl/loa_sample_ram.sv
// loa_sample_ram: simple dual-port sample store with registered, resettable read port
module loa_sample_ram #(
  parameter int DW = 8,
  parameter int AW = 8
)(
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk_50M) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk_50M) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/loa_capture.sv
// loa_capture: triggered sample capture into RAM with valid/ready readout
module loa_capture
  import loa_pkg::*;
#(
  parameter int DW = LOA_DW,
  parameter int DEPTH = LOA_DEPTH
)(
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          samp_en,
  input  logic [DW-1:0] din,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_val,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          triggered,
  output logic          done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  loa_state_t state, state_nx;
  logic [DW-1:0] s1, s2;
  logic [AW-1:0] wptr, wptr_nx, waddr;
  logic [AW:0] rptr, rptr_nx;
  logic we, re, hit, accept, rv_nx, rl_nx, trig_nx, done_nx;
  assign busy = state != IDLE;
  assign hit = ((s2 ^ trig_val) & trig_mask) == '0;
  assign accept = rd_valid && rd_ready;
  always_comb begin
    state_nx = state;
    we = 1'b0;
    waddr = wptr;
    wptr_nx = wptr;
    re = 1'b0;
    rptr_nx = rptr;
    rv_nx = rd_valid;
    rl_nx = rd_last;
    trig_nx = triggered;
    done_nx = 1'b0;
    case (state)
      IDLE: state_nx = arm ? ARMED : IDLE;
      ARMED: if (samp_en && hit) begin
        we = 1'b1;
        waddr = '0;
        wptr_nx = AW'(1);
        trig_nx = 1'b1;
        state_nx = CAPTURE;
      end
      CAPTURE: if (samp_en) begin
        we = 1'b1;
        wptr_nx = wptr + 1'b1;
        if (wptr == LAST) begin
          state_nx = READOUT;
          rptr_nx = '0;
        end
      end
      default: begin
        if (accept) rv_nx = 1'b0;
        // RAM output only advances when the beat is empty or being taken, so a stall holds it
        if ((!rd_valid || rd_ready) && !rptr[AW]) begin
          re = 1'b1;
          rptr_nx = rptr + 1'b1;
          rv_nx = 1'b1;
          rl_nx = rptr[AW-1:0] == LAST;
        end
        if (accept && rd_last) begin
          state_nx = IDLE;
          rv_nx = 1'b0;
          rl_nx = 1'b0;
          trig_nx = 1'b0;
          done_nx = 1'b1;
        end
      end
    endcase
    if (abort || rst) begin
      state_nx = IDLE;
      we = 1'b0;
      re = 1'b0;
      rv_nx = 1'b0;
      rl_nx = 1'b0;
      trig_nx = 1'b0;
      done_nx = 1'b0;
    end
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      wptr <= '0;
      rptr <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      triggered <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      s1 <= din;
      s2 <= s1;
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      rd_valid <= rv_nx;
      rd_last <= rl_nx;
      triggered <= trig_nx;
      done <= done_nx;
    end
  end
  loa_sample_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk_50M(clk_50M),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(s2),
    .re(re),
    .raddr(rptr[AW-1:0]),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_loa_capture.sv
// tb_loa_capture: directed checks of capture, trigger, backpressure, abort and reset
module tb_loa_capture;
  logic clk_50M = 1'b0;
  logic rst = 1'b1, samp_en = 1'b0, arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
  logic [7:0] din = 8'd0, trig_mask = 8'd0, trig_val = 8'd0;
  logic rd_valid, rd_last, busy, triggered, done;
  logic [7:0] rd_data;
  logic ramp = 1'b0;
  int n_cmp = 0, n_err = 0;
  always #10 clk_50M = ~clk_50M;
  loa_capture dut (
    .clk_50M(clk_50M), .rst(rst), .samp_en(samp_en), .din(din), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_val(trig_val), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk_50M);
    if (ramp) din = din + 8'd1;
  endtask
  // Full-rate ramp capture; the beat stored first is the ramp value one below the one driven with arm
  task automatic run_full(input int stop_at);
    logic [7:0] d0;
    int cnt;
    int dcnt;
    dcnt = 0;
    ramp = 1'b1;
    samp_en = 1'b1;
    trig_mask = 8'd0;
    rd_ready = 1'b1;
    step();
    arm = 1'b1;
    d0 = din;
    step();
    arm = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_trig_low", 32'(triggered), 32'd0);
    cnt = 1;
    while (!rd_valid && cnt < 400) begin
      step();
      cnt++;
    end
    chk("first_valid_latency", 32'(cnt), 32'd258);
    chk("trig_high", 32'(triggered), 32'd1);
    for (int k = 0; k < stop_at; k++) begin
      chk("beat_valid", 32'(rd_valid), 32'd1);
      chk("beat_data", 32'(rd_data), 32'(8'(d0 - 8'd1 + 8'(k))));
      chk("beat_last", 32'(rd_last), 32'(k == 255));
      if (done) dcnt++;
      step();
    end
    if (stop_at < 256) begin
      abort = 1'b1;
      rd_ready = 1'b0;
      step();
      abort = 1'b0;
      chk("abort_ro_busy", 32'(busy), 32'd0);
      chk("abort_ro_valid", 32'(rd_valid), 32'd0);
      chk("abort_ro_trig", 32'(triggered), 32'd0);
      if (done) dcnt++;
      step();
      if (done) dcnt++;
      chk("abort_ro_no_done", 32'(dcnt), 32'd0);
    end else begin
      chk("full_done", 32'(done), 32'd1);
      chk("full_busy", 32'(busy), 32'd0);
      chk("full_valid", 32'(rd_valid), 32'd0);
      chk("full_trig", 32'(triggered), 32'd0);
      chk("full_last", 32'(rd_last), 32'd0);
      dcnt++;
      step();
      if (done) dcnt++;
      chk("full_done_once", 32'(dcnt), 32'd1);
    end
    ramp = 1'b0;
  endtask
  initial begin
    int tcnt, beats, dcnt;
    logic stall, hl;
    logic [7:0] hd, ev;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("armed_busy", 32'(busy), 32'd1);
    step();
    chk("armed_wait", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_armed_busy", 32'(busy), 32'd0);
    chk("abort_armed_valid", 32'(rd_valid), 32'd0);
    chk("abort_armed_done", 32'(done), 32'd0);
    run_full(100);
    run_full(256);
    trig_mask = 8'h0F;
    trig_val = 8'h05;
    samp_en = 1'b0;
    din = 8'h30;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    tcnt = 0;
    for (int m = 0; m < 100; m++)
      for (int j = 0; j < 10; j++) begin
        samp_en = (j == 9);
        step();
        if (triggered) tcnt++;
      end
    chk("pat_no_early_trig", 32'(tcnt), 32'd0);
    chk("pat_still_armed", 32'(busy), 32'd1);
    for (int m = 0; m < 256; m++) begin
      din = (m == 0) ? 8'hA5 : 8'(m);
      for (int j = 0; j < 10; j++) begin
        samp_en = (j == 9);
        step();
      end
      if (m == 0) chk("pat_trig_on_strobe", 32'(triggered), 32'd1);
    end
    samp_en = 1'b0;
    beats = 0;
    dcnt = 0;
    stall = 1'b0;
    hd = 8'd0;
    hl = 1'b0;
    for (int c = 0; c < 6000 && beats < 256; c++) begin
      step();
      if (done) dcnt++;
      if (stall) begin
        chk("stall_valid", 32'(rd_valid), 32'd1);
        chk("stall_data", 32'(rd_data), 32'(hd));
        chk("stall_last", 32'(rd_last), 32'(hl));
      end
      rd_ready = ($urandom_range(9, 0) < 3);
      stall = rd_valid && !rd_ready;
      hd = rd_data;
      hl = rd_last;
      if (rd_valid && rd_ready) begin
        ev = (beats == 0) ? 8'hA5 : 8'(beats);
        chk("bp_data", 32'(rd_data), 32'(ev));
        chk("bp_last", 32'(rd_last), 32'(beats == 255));
        beats++;
      end
    end
    chk("bp_beats", 32'(beats), 32'd256);
    step();
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_busy", 32'(busy), 32'd0);
    if (done) dcnt++;
    chk("bp_done_once", 32'(dcnt), 32'd1);
    rd_ready = 1'b1;
    ramp = 1'b1;
    samp_en = 1'b1;
    trig_mask = 8'd0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (50) step();
    chk("mid_cap_busy", 32'(busy), 32'd1);
    chk("mid_cap_trig", 32'(triggered), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_last", 32'(rd_last), 32'd0);
    chk("midrst_data", 32'(rd_data), 32'd0);
    chk("midrst_trig", 32'(triggered), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle", 32'(busy), 32'd0);
    step();
    chk("arm_abort_stays_idle", 32'(busy), 32'd0);
    ramp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/loa_capture.md
LOA_CAPTURE -- requirements
Module: loa_capture

Interface
REQ-001 Parameter: DW, 8, probe channel count and sample width.
REQ-002 Parameter: DEPTH, 256, samples per capture; power of two, AW = log2(DEPTH).
REQ-003 clk_50M  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 samp_en  in  1  sample-enable strobe from the frequency divider; one-cycle pulses, or constant 1 in full-rate mode.
REQ-006 din  in  DW  asynchronous probe inputs.
REQ-007 arm  in  1  single-cycle request to start an acquisition.
REQ-008 abort  in  1  single-cycle request to cancel any activity.
REQ-009 trig_mask  in  DW  channels participating in the trigger; 1 means compared.
REQ-010 trig_val  in  DW  required level on masked channels.
REQ-011 rd_valid  out  1  readout beat valid.
REQ-012 rd_ready  in  1  readout beat accepted by the consumer.
REQ-013 rd_data  out  DW  readout sample.
REQ-014 rd_last  out  1  marks sample DEPTH-1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 triggered  out  1  trigger seen in the current acquisition.
REQ-017 done  out  1  one-cycle pulse when the final beat is accepted.

Function
REQ-018 din shall pass through a 2-flop synchroniser; "sample" is the second stage's value in a samp_en cycle.
REQ-019 The FSM shall have states IDLE, ARMED, CAPTURE and READOUT.
REQ-020 IDLE -> ARMED on arm; arm shall be ignored in all other states.
REQ-021 ARMED: on samp_en with ((sample ^ trig_val) & trig_mask) == 0, write the sample to address 0, set triggered, set the write pointer to 1, go to CAPTURE; trig_mask == 0 triggers on the first samp_en.
REQ-022 CAPTURE: each samp_en writes the sample at the write pointer and increments it; the write at address DEPTH-1 moves to READOUT the next cycle.
REQ-023 With samp_en constantly 1, the block shall capture every cycle with no gaps; DEPTH consecutive synchronised samples shall be stored.
REQ-024 samp_en outside ARMED/CAPTURE shall have no effect.
REQ-025 READOUT shall present addresses 0..DEPTH-1 in order with a valid/ready handshake, and rd_last shall be high only with address DEPTH-1.
REQ-026 The first rd_valid shall assert exactly 2 cycles after the final capture write; memory read is registered.
REQ-027 Sustained rd_ready=1 shall yield one beat per cycle (prefetch or skid stage required).
REQ-028 While rd_valid=1 and rd_ready=0, rd_data and rd_last shall hold stable.
REQ-029 When the rd_last beat is accepted, done shall pulse and the FSM shall go to IDLE; rd_valid and triggered shall clear the same cycle.
REQ-030 abort in any state shall return to IDLE next cycle, clear rd_valid and triggered, and not pulse done; abort overrides arm in the same cycle.
REQ-031 trig_mask and trig_val shall be sampled live; the consumer holds them stable while ARMED.

Reset
REQ-032 rst shall force IDLE, pointers 0, rd_valid=0, rd_last=0, rd_data=0, triggered=0, done=0, busy=0 and synchroniser flops 0; memory contents are not reset.
REQ-033 rst mid-capture or mid-readout shall behave as REQ-032 with no done pulse; rst overrides abort and arm.

Structure
REQ-034 The FSM state encoding and the DW/DEPTH defaults shall live in the shared logic-analyser package.
REQ-035 Sample storage shall be a sub-module, loa_sample_ram: simple dual-port, one write and one registered read port, inferable as block RAM.

Verification
REQ-036 Full-rate capture: samp_en=1, mask=0, din ramps 0..255 per cycle, arm -> 256 beats in ramp order offset by 2 (synchroniser), rd_last on beat 255, done once.
REQ-037 Pattern trigger: mask=8'h0F, val=8'h05, samp_en every 10 cycles, din=8'hA5 appears after 1000 cycles -> beat 0 = 8'hA5, triggered=1 from that strobe.
REQ-038 Backpressure: random rd_ready at 30% duty -> no lost/duplicated beats, rd_data stable while stalled, 256 beats total.
REQ-039 Abort while ARMED and at beat 100 of READOUT -> IDLE next cycle, rd_valid=0, busy=0, no done; a new arm then captures normally.
REQ-040 rst asserted mid-CAPTURE for one cycle -> all outputs at reset values next cycle; arm in the same cycle as abort -> stays IDLE.
